// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated with an idle-low gap.
// Latency: first bit appears on SerOut at the same edge that accepts Start; one bit per cycle.
// Backpressure: none; Start is ignored while Busy, invalid lengths pulse Err, Abort cancels.
module serial_pattern_tx #(
    parameter int PAT_W      = 8,
    parameter int LEN_W      = 4,
    parameter int REP_W      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [PAT_W-1:0] Pattern,
    input  logic [LEN_W-1:0] Length,
    input  logic [REP_W-1:0] Repeat,
    input  logic             Abort,
    output logic             SerOut,
    output logic             BitValid,
    output logic             Busy,
    output logic             Done,
    output logic             Err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state, state_nxt;
    logic [PAT_W-1:0] pat_q, pat_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic [LEN_W-1:0] idx_q, idx_nxt;
    logic [REP_W-1:0] rep_q, rep_nxt;
    logic [GAP_W-1:0] gap_q, gap_nxt;
    logic             ser_nxt, bv_nxt, busy_nxt, done_nxt, err_nxt;

    // Shift-based bit select keeps the index width independent of PAT_W.
    function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
        logic [PAT_W-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    always_comb begin
        state_nxt = state;
        pat_nxt   = pat_q;
        len_nxt   = len_q;
        idx_nxt   = idx_q;
        rep_nxt   = rep_q;
        gap_nxt   = gap_q;
        ser_nxt   = 1'b0;
        bv_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Length == '0 || Length > LEN_W'(PAT_W)) begin
                        err_nxt = 1'b1;
                    end else begin
                        pat_nxt   = Pattern;
                        len_nxt   = Length;
                        rep_nxt   = Repeat;
                        idx_nxt   = Length - LEN_W'(1);
                        ser_nxt   = bit_at(Pattern, Length - LEN_W'(1));
                        bv_nxt    = 1'b1;
                        busy_nxt  = 1'b1;
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (Abort) begin
                    state_nxt = IDLE;
                end else if (idx_q != '0) begin
                    idx_nxt  = idx_q - LEN_W'(1);
                    ser_nxt  = bit_at(pat_q, idx_q - LEN_W'(1));
                    bv_nxt   = 1'b1;
                    busy_nxt = 1'b1;
                end else if (rep_q != '0) begin
                    rep_nxt  = rep_q - REP_W'(1);
                    busy_nxt = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        idx_nxt = len_q - LEN_W'(1);
                        ser_nxt = bit_at(pat_q, len_q - LEN_W'(1));
                        bv_nxt  = 1'b1;
                    end else begin
                        state_nxt = GAP;
                        gap_nxt   = GAP_W'(GAP_CYCLES - 1);
                    end
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            GAP: begin
                if (Abort) begin
                    state_nxt = IDLE;
                end else begin
                    busy_nxt = 1'b1;
                    if (gap_q == '0) begin
                        state_nxt = SHIFT;
                        idx_nxt   = len_q - LEN_W'(1);
                        ser_nxt   = bit_at(pat_q, len_q - LEN_W'(1));
                        bv_nxt    = 1'b1;
                    end else begin
                        gap_nxt = gap_q - GAP_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            pat_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            rep_q    <= '0;
            gap_q    <= '0;
            SerOut   <= 1'b0;
            BitValid <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            pat_q    <= pat_nxt;
            len_q    <= len_nxt;
            idx_q    <= idx_nxt;
            rep_q    <= rep_nxt;
            gap_q    <= gap_nxt;
            SerOut   <= ser_nxt;
            BitValid <= bv_nxt;
            Busy     <= busy_nxt;
            Done     <= done_nxt;
            Err      <= err_nxt;
        end
    end

endmodule
